// File: rtl/apb_rr_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_rr_pkg;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW:0] j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (!any && req[j[IW-1:0]]) begin
        grant[j[IW-1:0]] = 1'b1;
        grant_idx        = j[IW-1:0];
        any              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NUM_REQ requesters through a round-robin arbiter.
//   state      | meaning
//   APB_IDLE   | arbitrate; latch winner's command, pulse req_ready
//   APB_SETUP  | PSEL=1, PENABLE=0 for one cycle
//   APB_ACCESS | PSEL=1, PENABLE=1 until PREADY or wait-state timeout
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PERROR
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d, pwdata_q, pwdata_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                rsp_error_q, rsp_error_d, psel_q, psel_d;
  logic                penable_q, penable_d, pwrite_q, pwrite_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CW'(1);
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (arb_any) begin
          req_ready_d = arb_grant;
          owner_d     = arb_idx;
          pwrite_d    = req_write[arb_idx];
          paddr_d     = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          pwdata_d    = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          ptr_d       = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = APB_SETUP;
        end
      end
      APB_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = APB_ACCESS;
      end
      APB_ACCESS: begin
        // PREADY is checked first so a ready on the last allowed cycle completes normally.
        if (PREADY || cnt_inc == CW'(TIMEOUT)) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = APB_IDLE;
          if (PREADY) begin
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            rsp_error_d = PERROR;
          end else begin
            rsp_error_d = 1'b1;
            cnt_d       = cnt_inc;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= APB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master with a small memory-backed APB slave model.
module tb_apb_rr_master;
  logic        PCLK, PRESET;
  logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [15:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic        rsp_error, PSEL, PENABLE, PWRITE, PREADY, PERROR;

  apb_rr_master #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PERROR(PERROR)
  );

  typedef struct {
    int          idx;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] mem [0:255];
  bit          hang = 0;
  int          slave_wait = 0;

  initial begin
    PCLK = 0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: PREADY after slave_wait ACCESS cycles unless hang; address EEE0 reports PERROR.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    PREADY = 0; PERROR = 0; PRDATA = 16'h5A5A;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (!hang && acc_cnt >= slave_wait) begin
          PREADY = 1;
          PERROR = (PADDR == 16'hEEE0);
          PRDATA = mem[PADDR[7:0]];
          if (PWRITE) mem[PADDR[7:0]] = PWDATA;
        end else begin
          PREADY = 0; PERROR = 0; PRDATA = 16'h5A5A;
        end
        acc_cnt++;
      end else begin
        PREADY = 0; PERROR = 0; PRDATA = 16'h5A5A;
        acc_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (!PRESET && rsp_valid != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 32'(rsp_valid), 32'(4'b1 << e.idx));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_error", 32'(rsp_error), 32'(e.err));
          if (e.cyc >= 0) check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic push(input int k, input logic [15:0] rd, input logic err, input int c);
    exp_t e;
    e.idx = k; e.rdata = rd; e.err = err; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d);
    req_write[k]        = wr;
    req_addr[k*16 +: 16]  = a;
    req_wdata[k*16 +: 16] = d;
    req_valid[k]        = 1'b1;
  endtask

  task automatic wait_grant(input int k, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (req_ready == 4'b0 && n < 50);
    check("grant", 32'(req_ready), 32'(4'b1 << k));
    if (drop) req_valid[k] = 1'b0;
  endtask

  task automatic issue(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err, input int extra);
    @(negedge PCLK);
    set_req(k, wr, a, d);
    push(k, exp_rd, exp_err, (extra < 0) ? -1 : cyc + 3 + extra);
    wait_grant(k, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    PRESET = 1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_paddr", 32'(PADDR), 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    PRESET = 0;

    // Fairness: all four requesters held valid from ptr=0.
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, 16'h0020 + 16'(i), 16'h0);
      push(i, 16'hA020 + 16'(i), 1'b0, -1);
    end
    push(0, 16'hA020, 1'b0, -1);
    for (int g = 0; g < 5; g++) wait_grant(g % 4, 1'b0);
    req_valid = '0;
    drain(60);

    issue(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 0);
    drain(20);
    issue(1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
    drain(20);
    issue(1, 1'b0, 16'hEEE0, 16'h0000, 16'hA0E0, 1'b1, 0);
    drain(20);

    // Three wait states: command must stay put from SETUP to ACCESS exit.
    slave_wait = 3;
    issue(2, 1'b1, 16'h0030, 16'h1234, 16'h0000, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      check("ws_psel", 32'(PSEL), 32'h1);
      check("ws_paddr", 32'(PADDR), 32'h0030);
      check("ws_pwdata", 32'(PWDATA), 32'h1234);
      if (i < 4) @(negedge PCLK);
    end
    drain(20);

    slave_wait = 15;
    issue(3, 1'b0, 16'h0041, 16'h0000, 16'hA041, 1'b0, 15);
    drain(40);
    slave_wait = 0;

    hang = 1;
    issue(3, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1, 15);
    drain(40);
    check("to_psel", 32'(PSEL), 32'h0);
    check("to_penable", 32'(PENABLE), 32'h0);
    hang = 0;
    issue(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
    drain(20);

    // Reset in ACCESS with ptr parked on r3; r0 must win afterwards.
    hang = 1;
    @(negedge PCLK);
    set_req(2, 1'b0, 16'h0060, 16'h0);
    wait_grant(2, 1'b1);
    n = 0;
    while (!(PSEL && PENABLE) && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    check("pre_rst_access", 32'(PSEL && PENABLE), 32'h1);
    @(negedge PCLK);
    #1 PRESET = 1;
    #1;
    check("mid_rst_psel", 32'(PSEL), 32'h0);
    check("mid_rst_penable", 32'(PENABLE), 32'h0);
    hang = 0;
    repeat (2) @(negedge PCLK);
    PRESET = 0;
    @(negedge PCLK);
    set_req(0, 1'b0, 16'h0050, 16'h0);
    set_req(3, 1'b0, 16'h0053, 16'h0);
    push(0, 16'hA050, 1'b0, cyc + 3);
    push(3, 16'hA053, 1'b0, -1);
    wait_grant(0, 1'b1);
    wait_grant(3, 1'b1);
    drain(30);
    repeat (3) @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
